direction_flag: RTL and testbench

- Combines the Pac-Man sprite's position with a static tile-based maze map.
- Reports, for each of the four directions, how many 1-pixel steps the sprite can take before touching a wall, saturated at 7.
- A flag of 0 means that direction is blocked.
- Sits beside the pacman movement logic, which uses non-zero flags to accept button turns and to advance the position.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/direction_flag_if.sv | 12 +
 rtl/direction_flag_probe.sv | 53 +++++
 rtl/direction_flag.sv | 57 +++++
 tb/tb_direction_flag.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared maze geometry: tile size, grid size, step saturation limit,
// the default bordered wall map and the wall lookup helper.
package maze_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int GRID_DIM   = 32;
    localparam int FLAG_MAX   = 7;

    // Walls on the outer ring of tiles; every interior tile is free.
    function automatic logic [1023:0] build_border_maze();
        logic [1023:0] maze_v;
        maze_v = '0;
        for (int r = 0; r < GRID_DIM; r++) begin
            for (int c = 0; c < GRID_DIM; c++) begin
                if (r == 0 || r == GRID_DIM - 1 || c == 0 || c == GRID_DIM - 1) begin
                    maze_v[r * GRID_DIM + c] = 1'b1;
                end
            end
        end
        return maze_v;
    endfunction

    localparam logic [1023:0] MAZE_DEFAULT = build_border_maze();

    function automatic logic is_wall(input logic [1023:0] maze,
                                     input logic [4:0]    row,
                                     input logic [4:0]    col);
        return maze[{row, col}];
    endfunction

endpackage

// File: rtl/direction_flag_if.sv
// Sprite position in, per-direction free-step flags out.
interface direction_flag_if;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] flag_L;
    logic [2:0] flag_U;
    logic [2:0] flag_R;
    logic [2:0] flag_D;

    modport master (output x, y, input  flag_L, flag_U, flag_R, flag_D);
    modport slave  (input  x, y, output flag_L, flag_U, flag_R, flag_D);
endinterface

// File: rtl/direction_flag_probe.sv
// Counts free pixels (0..FLAG_MAX) beyond one edge of the sprite box along
// one axis; range violations below 0 or past 511 count as walls.
module dir_probe
    import maze_pkg::*;
#(
    parameter bit             AXIS       = 1'b0,   // 0: horizontal, 1: vertical
    parameter bit             SIGN       = 1'b0,   // 0: decreasing, 1: increasing
    parameter logic [1023:0]  MAZE       = MAZE_DEFAULT,
    parameter int             TILE_SHIFT = maze_pkg::TILE_SHIFT
) (
    input  logic [8:0] pos,
    input  logic [4:0] cross0,
    input  logic [4:0] cross1,
    output logic [2:0] steps
);

    logic signed [10:0] pix_s;
    logic [4:0]         tile_s;
    logic               blocked_s;
    logic               open_s;
    logic [2:0]         count_s;

    // Walk outward pixel by pixel; the count freezes at the first blocked pixel.
    always_comb begin
        pix_s     = 11'sd0;
        tile_s    = 5'd0;
        blocked_s = 1'b0;
        open_s    = 1'b1;
        count_s   = 3'd0;
        for (int k = 1; k <= FLAG_MAX; k++) begin
            if (SIGN) begin
                pix_s = $signed({2'b00, pos}) + 11'sd15 + $signed(11'(k));
            end else begin
                pix_s = $signed({2'b00, pos}) - $signed(11'(k));
            end
            tile_s = 5'(pix_s[9:0] >> TILE_SHIFT);
            if (pix_s < 11'sd0 || pix_s > 11'sd511) begin
                blocked_s = 1'b1;
            end else if (AXIS == 1'b0) begin
                blocked_s = is_wall(MAZE, cross0, tile_s) || is_wall(MAZE, cross1, tile_s);
            end else begin
                blocked_s = is_wall(MAZE, tile_s, cross0) || is_wall(MAZE, tile_s, cross1);
            end
            if (open_s && !blocked_s) begin
                count_s = 3'(k);
            end else begin
                open_s = 1'b0;
            end
        end
        steps = count_s;
    end

endmodule

// File: rtl/direction_flag.sv
// Registered free-step flags in four directions for a 16x16 sprite on a
// static tile maze; one probe per direction.
module direction_flag
    import maze_pkg::*;
#(
    parameter logic [1023:0] MAZE       = MAZE_DEFAULT,
    parameter int            TILE_SHIFT = maze_pkg::TILE_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    direction_flag_if.slave  bus
);

    logic [9:0] x_end_s;
    logic [9:0] y_end_s;
    logic [4:0] col0_s;
    logic [4:0] col1_s;
    logic [4:0] row0_s;
    logic [4:0] row1_s;
    logic [2:0] left_s;
    logic [2:0] up_s;
    logic [2:0] right_s;
    logic [2:0] down_s;

    // Tiles touched by the box; first and last coincide when tile-aligned.
    assign x_end_s = {1'b0, bus.x} + 10'd15;
    assign y_end_s = {1'b0, bus.y} + 10'd15;
    assign col0_s  = 5'(bus.x   >> TILE_SHIFT);
    assign col1_s  = 5'(x_end_s >> TILE_SHIFT);
    assign row0_s  = 5'(bus.y   >> TILE_SHIFT);
    assign row1_s  = 5'(y_end_s >> TILE_SHIFT);

    dir_probe #(.AXIS(1'b0), .SIGN(1'b0), .MAZE(MAZE), .TILE_SHIFT(TILE_SHIFT)) u_left (
        .pos(bus.x), .cross0(row0_s), .cross1(row1_s), .steps(left_s));
    dir_probe #(.AXIS(1'b1), .SIGN(1'b0), .MAZE(MAZE), .TILE_SHIFT(TILE_SHIFT)) u_up (
        .pos(bus.y), .cross0(col0_s), .cross1(col1_s), .steps(up_s));
    dir_probe #(.AXIS(1'b0), .SIGN(1'b1), .MAZE(MAZE), .TILE_SHIFT(TILE_SHIFT)) u_right (
        .pos(bus.x), .cross0(row0_s), .cross1(row1_s), .steps(right_s));
    dir_probe #(.AXIS(1'b1), .SIGN(1'b1), .MAZE(MAZE), .TILE_SHIFT(TILE_SHIFT)) u_down (
        .pos(bus.y), .cross0(col0_s), .cross1(col1_s), .steps(down_s));

    // All four flags register together; reset forces every direction blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.flag_L <= 3'd0;
            bus.flag_U <= 3'd0;
            bus.flag_R <= 3'd0;
            bus.flag_D <= 3'd0;
        end else begin
            bus.flag_L <= left_s;
            bus.flag_U <= up_s;
            bus.flag_R <= right_s;
            bus.flag_D <= down_s;
        end
    end

endmodule

// File: tb/tb_direction_flag.sv
// Directed and random checks of direction_flag against a pixel-walk model,
// using the default maze and a maze with one extra interior wall tile.
module tb_direction_flag;
    import maze_pkg::*;

    localparam logic [1023:0] MAZE_T = MAZE_DEFAULT | (1024'd1 << (14 * 32 + 14));

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    direction_flag_if bus0 ();
    direction_flag_if bus1 ();

    direction_flag #(.MAZE(MAZE_DEFAULT), .TILE_SHIFT(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    direction_flag #(.MAZE(MAZE_T),       .TILE_SHIFT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #10 clk = ~clk;

    // dir: 0=L 1=U 2=R 3=D. Walk pixels strictly outside the 16x16 box.
    function automatic int model_flag(input bit [1023:0] m, input int dir, input int x, input int y);
        int c0 = x / 16, c1 = (x + 15) / 16, r0 = y / 16, r1 = (y + 15) / 16;
        int n = 0;
        for (int k = 1; k <= 7; k++) begin
            int p;
            bit blk;
            bit horiz = (dir == 0 || dir == 2);
            case (dir)
                0: p = x - k;
                1: p = y - k;
                2: p = x + 15 + k;
                default: p = y + 15 + k;
            endcase
            if (p < 0 || p > 511) blk = 1'b1;
            else if (horiz) blk = m[r0 * 32 + p / 16] | m[r1 * 32 + p / 16];
            else blk = m[(p / 16) * 32 + c0] | m[(p / 16) * 32 + c1];
            if (blk) break;
            n = k;
        end
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_xy(input int x, input int y);
        bus0.x = 9'(x); bus0.y = 9'(y);
        bus1.x = 9'(x); bus1.y = 9'(y);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag, input int x, input int y);
        check({tag, "_L0"}, int'(bus0.flag_L), model_flag(MAZE_DEFAULT, 0, x, y));
        check({tag, "_U0"}, int'(bus0.flag_U), model_flag(MAZE_DEFAULT, 1, x, y));
        check({tag, "_R0"}, int'(bus0.flag_R), model_flag(MAZE_DEFAULT, 2, x, y));
        check({tag, "_D0"}, int'(bus0.flag_D), model_flag(MAZE_DEFAULT, 3, x, y));
        check({tag, "_L1"}, int'(bus1.flag_L), model_flag(MAZE_T, 0, x, y));
        check({tag, "_U1"}, int'(bus1.flag_U), model_flag(MAZE_T, 1, x, y));
        check({tag, "_R1"}, int'(bus1.flag_R), model_flag(MAZE_T, 2, x, y));
        check({tag, "_D1"}, int'(bus1.flag_D), model_flag(MAZE_T, 3, x, y));
    endtask

    task automatic check_all0(input string tag, input int l, input int u, input int r, input int d);
        check({tag, "_L"}, int'(bus0.flag_L), l);
        check({tag, "_U"}, int'(bus0.flag_U), u);
        check({tag, "_R"}, int'(bus0.flag_R), r);
        check({tag, "_D"}, int'(bus0.flag_D), d);
    endtask

    initial begin
        int rx, ry;

        // Reset with sprite in open space
        rst = 1'b1;
        set_xy(200, 230);
        step();
        step();
        check_all0("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check_all0("release", 7, 7, 7, 7);

        // Left wall contact and partial clearance
        set_xy(16, 100);
        step();
        check("lwall_L", int'(bus0.flag_L), 0);
        check("lwall_R", int'(bus0.flag_R), 7);
        set_xy(20, 100);
        step();
        check("lwall4_L", int'(bus0.flag_L), 4);

        // Latency: input change is not visible until the next edge
        set_xy(17, 100);
        #2;
        check("lat_hold_L", int'(bus0.flag_L), 4);
        step();
        check("lat_upd_L", int'(bus0.flag_L), 1);

        // Top/right corner
        set_xy(480, 16);
        step();
        check_all0("corner", 7, 0, 0, 7);

        // Coordinate range edge: no wrap to column 511
        set_xy(0, 100);
        step();
        check("edge0_L", int'(bus0.flag_L), 0);
        check_model("edge0", 0, 100);

        // Interior wall tile (14,14) only in dut1
        set_xy(205, 230);
        step();
        check("iwall_R", int'(bus1.flag_R), 3);
        check("iwall_R_dflt", int'(bus0.flag_R), 7);
        set_xy(205, 250);
        step();
        check("iwall_rows_R", int'(bus1.flag_R), 7);

        // Mid-run single-cycle reset
        set_xy(20, 100);
        rst = 1'b1;
        step();
        check_all0("midrst", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check_all0("postrst", 4, 7, 7, 7);

        // Random positions over both mazes, biased half the time near tile (14,14)
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                rx = int'($urandom_range(0, 496));
                ry = int'($urandom_range(0, 496));
            end else begin
                rx = int'($urandom_range(190, 250));
                ry = int'($urandom_range(190, 250));
            end
            set_xy(rx, ry);
            step();
            check_model($sformatf("rnd%0d_x%0d_y%0d", i, rx, ry), rx, ry);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
